// File: rtl/wrr_burst_arbiter_if.sv
// Request/grant bundle between requesters and the weighted round-robin burst arbiter.
// Requesters drive request/last/weight; the arbiter drives grant/select/active.
interface wrr_burst_arbiter_if #(
    parameter int NUM_PORTS    = 4,
    parameter int SEL_WIDTH    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    parameter int WEIGHT_WIDTH = 4
);
    logic [NUM_PORTS-1:0]              request;
    logic [NUM_PORTS-1:0]              last;
    logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight;
    logic [NUM_PORTS-1:0]              grant;
    logic [SEL_WIDTH-1:0]              select;
    logic                              active;

    modport master (
        output request, last, weight,
        input  grant, select, active
    );

    modport slave (
        input  request, last, weight,
        output grant, select, active
    );
endinterface

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter with burst ownership: a granted port keeps the
// resource for up to weight[p] beats, or until it signals last or drops request.
module wrr_burst_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int SEL_WIDTH    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    wrr_burst_arbiter_if.slave bus
);
    localparam int unsigned NP = NUM_PORTS;

    typedef enum logic {IDLE, OWN} state_t;

    state_t                  state;
    logic [SEL_WIDTH-1:0]    ptr;
    logic [WEIGHT_WIDTH-1:0] credit;

    logic                    found;
    logic [SEL_WIDTH-1:0]    win;
    logic [SEL_WIDTH-1:0]    win_next_ptr;
    logic [WEIGHT_WIDTH-1:0] win_weight;
    logic [WEIGHT_WIDTH-1:0] win_credit;
    logic                    beat;
    logic                    release_now;
    logic                    load;
    logic                    clear;
    int unsigned             idx;

    // Round-robin search starting at ptr; the current owner sits last in the
    // order, so it only wins again when nobody else is requesting.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NP; i++) begin
            idx = (32'(ptr) + i) % NP;
            if (!found && bus.request[SEL_WIDTH'(idx)]) begin
                found = 1'b1;
                win   = SEL_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        win_weight   = bus.weight[win*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        win_credit   = (win_weight == '0) ? WEIGHT_WIDTH'(1) : win_weight;
        win_next_ptr = (32'(win) + 32'd1 >= NP) ? '0 : SEL_WIDTH'(32'(win) + 32'd1);
    end

    // Release and re-arbitration share one edge, so a handover never leaves a bubble.
    always_comb begin
        beat        = bus.request[bus.select] && bus.grant[bus.select];
        release_now = !bus.request[bus.select] ||
                      (beat && ((credit == WEIGHT_WIDTH'(1)) || bus.last[bus.select]));
        load        = found && ((state == IDLE) || release_now);
        clear       = (state == OWN) && release_now && !found;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bus.grant  <= '0;
            bus.select <= '0;
            bus.active <= 1'b0;
            credit     <= '0;
            ptr        <= '0;
        end else if (load) begin
            state      <= OWN;
            bus.grant  <= NUM_PORTS'(1) << win;
            bus.select <= win;
            bus.active <= 1'b1;
            credit     <= win_credit;
            ptr        <= win_next_ptr;
        end else if (clear) begin
            state      <= IDLE;
            bus.grant  <= '0;
            bus.select <= '0;
            bus.active <= 1'b0;
            credit     <= '0;
        end else if ((state == OWN) && beat) begin
            credit <= credit - 1'b1;
        end
    end
endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench for wrr_burst_arbiter: vector table for the steady-state rotations,
// hand-written sequences for last, request drop, zero weight and async reset.
module tb_wrr_burst_arbiter;
    localparam int NP = 4;
    localparam int SW = 2;
    localparam int WW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    wrr_burst_arbiter_if #(.NUM_PORTS(NP), .SEL_WIDTH(SW), .WEIGHT_WIDTH(WW)) bus ();

    wrr_burst_arbiter #(.NUM_PORTS(NP), .SEL_WIDTH(SW), .WEIGHT_WIDTH(WW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         rst_before;
        logic [3:0]  req;
        logic [3:0]  lst;
        logic [15:0] wt;
        logic [3:0]  g;
        logic [1:0]  s;
        logic        a;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit r, input logic [3:0] req, input logic [15:0] wt,
                                input logic [3:0] g, input logic [1:0] s);
        vec_t v;
        v.rst_before = r;
        v.req        = req;
        v.lst        = 4'h0;
        v.wt         = wt;
        v.g          = g;
        v.s          = s;
        v.a          = (g != 4'h0);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] g, input logic [1:0] s,
                             input logic a);
        check({name, ".grant"},  32'(bus.grant),  32'(g));
        check({name, ".select"}, 32'(bus.select), 32'(s));
        check({name, ".active"}, 32'(bus.active), 32'(a));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lst, input logic [15:0] wt);
        bus.request = req;
        bus.last    = lst;
        bus.weight  = wt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive(4'hF, 4'h0, 16'h1111);
        rst_n = 1'b0;
        step();
        check_out("reset", 4'h0, 2'd0, 1'b0);

        // Weight 1 everywhere: one-cycle rotation 0,1,2,3,0 with no idle gap.
        vecs.push_back(mk(1'b1, 4'hF, 16'h1111, 4'h1, 2'd0));
        vecs.push_back(mk(1'b0, 4'hF, 16'h1111, 4'h2, 2'd1));
        vecs.push_back(mk(1'b0, 4'hF, 16'h1111, 4'h4, 2'd2));
        vecs.push_back(mk(1'b0, 4'hF, 16'h1111, 4'h8, 2'd3));
        vecs.push_back(mk(1'b0, 4'hF, 16'h1111, 4'h1, 2'd0));
        // Weights p3..p0 = 4,2,1,3: p0 x3, p1 x1, p2 x2, p3 x4, then p0.
        vecs.push_back(mk(1'b1, 4'hF, 16'h4213, 4'h1, 2'd0));
        vecs.push_back(mk(1'b0, 4'hF, 16'h4213, 4'h1, 2'd0));
        vecs.push_back(mk(1'b0, 4'hF, 16'h4213, 4'h1, 2'd0));
        vecs.push_back(mk(1'b0, 4'hF, 16'h4213, 4'h2, 2'd1));
        vecs.push_back(mk(1'b0, 4'hF, 16'h4213, 4'h4, 2'd2));
        vecs.push_back(mk(1'b0, 4'hF, 16'h4213, 4'h4, 2'd2));
        vecs.push_back(mk(1'b0, 4'hF, 16'h4213, 4'h8, 2'd3));
        vecs.push_back(mk(1'b0, 4'hF, 16'h4213, 4'h8, 2'd3));
        vecs.push_back(mk(1'b0, 4'hF, 16'h4213, 4'h8, 2'd3));
        vecs.push_back(mk(1'b0, 4'hF, 16'h4213, 4'h8, 2'd3));
        vecs.push_back(mk(1'b0, 4'hF, 16'h4213, 4'h1, 2'd0));

        foreach (vecs[k]) begin
            if (vecs[k].rst_before) do_reset();
            drive(vecs[k].req, vecs[k].lst, vecs[k].wt);
            step();
            check_out($sformatf("vec%0d", k), vecs[k].g, vecs[k].s, vecs[k].a);
        end

        // last on the 3rd beat: p1 regranted at once with a fresh budget of 8.
        do_reset();
        drive(4'h2, 4'h0, 16'h0080);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("last.pre%0d", i), 4'h2, 2'd1, 1'b1);
        end
        drive(4'h2, 4'h2, 16'h0080);
        step();
        check_out("last.regrant", 4'h2, 2'd1, 1'b1);
        drive(4'h6, 4'h0, 16'h0080);
        for (int i = 0; i < 7; i++) begin
            step();
            check_out($sformatf("last.hold%0d", i), 4'h2, 2'd1, 1'b1);
        end
        step();
        check_out("last.handover", 4'h4, 2'd2, 1'b1);

        // p2 drops request mid-burst while p0 waits.
        do_reset();
        drive(4'h4, 4'h0, 16'h0888);
        step();
        check_out("drop.g1", 4'h4, 2'd2, 1'b1);
        step();
        check_out("drop.g2", 4'h4, 2'd2, 1'b1);
        drive(4'h1, 4'h0, 16'h0888);
        step();
        check_out("drop.p0", 4'h1, 2'd0, 1'b1);
        drive(4'h5, 4'h0, 16'h0888);
        for (int i = 0; i < 7; i++) begin
            step();
            check_out($sformatf("drop.hold%0d", i), 4'h1, 2'd0, 1'b1);
        end
        step();
        check_out("drop.p2back", 4'h4, 2'd2, 1'b1);

        // Zero weight behaves as one beat; then all requests vanish -> idle.
        do_reset();
        drive(4'h3, 4'h0, 16'h0030);
        step();
        check_out("w0.p0", 4'h1, 2'd0, 1'b1);
        step();
        check_out("w0.p1", 4'h2, 2'd1, 1'b1);
        step();
        check_out("w0.p1hold", 4'h2, 2'd1, 1'b1);
        drive(4'h0, 4'h0, 16'h0030);
        step();
        check_out("w0.idle", 4'h0, 2'd0, 1'b0);

        // Async reset between edges, then search restarts from port 0.
        do_reset();
        drive(4'h4, 4'h0, 16'h0800);
        step();
        check_out("arst.g1", 4'h4, 2'd2, 1'b1);
        step();
        check_out("arst.g2", 4'h4, 2'd2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("arst.clear", 4'h0, 2'd0, 1'b0);
        drive(4'hA, 4'h0, 16'h0800);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_out("arst.first", 4'h2, 2'd1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
